// File: rtl/sha256_pkg.sv
// SHA-256 message-schedule shared definitions: FSM states, block constants, round constants, rotate helper.
// Latency: n/a (package only).
// Backpressure: n/a. Build option SHA_PREADD_K_EN adds the 64-entry K table used for W_t+K_t pre-addition.
package sha256_pkg;

  // Words loaded per block and schedule words emitted per block; fixed by SHA-256.
  localparam int NLOAD   = 16;
  localparam int NROUNDS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } sched_state_t;

`ifdef SHA_PREADD_K_EN
  // Round constants K_0..K_63, indexed by schedule index t.
  localparam logic [31:0] K_TABLE [NROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  // 32-bit rotate right by a constant amount (n in 1..31).
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_w_sigma.sv
// Combinational SHA-256 schedule word: sigma1(W_t-2) + W_t-7 + sigma0(W_t-15) + W_t-16 mod 2^32.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is consumed.
module sha256_w_sigma
  import sha256_pkg::*;
(
  input  logic [31:0] w_m2,
  input  logic [31:0] w_m7,
  input  logic [31:0] w_m15,
  input  logic [31:0] w_m16,
  output logic [31:0] w_new
);

  logic [31:0] s0;
  logic [31:0] s1;

  // Small sigmas and the four-operand wrap-around sum; carries beyond bit 31 are dropped.
  always_comb begin
    s0    = rotr(w_m15, 7)  ^ rotr(w_m15, 18) ^ (w_m15 >> 3);
    s1    = rotr(w_m2, 17)  ^ rotr(w_m2, 19)  ^ (w_m2 >> 10);
    w_new = s1 + w_m7 + s0 + w_m16;
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads W_0..W_15 serially, expands W_16..W_63 from a 16-word sliding window.
// Latency: 1 cycle M_IN -> W_OUT in LOAD; one word per cycle in EXPAND while W_READY stays high.
// Backpressure: single output register advances when empty or taken; W_READY low holds W_OUT/T_IDX and stalls M_READY.
// Build option SHA_PREADD_K_EN: W_OUT carries W_t+K_t (window still keeps raw W_t).
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] M_IN,
  input  logic        M_VALID,
  output logic        M_READY,
  output logic [31:0] W_OUT,
  output logic        W_VALID,
  input  logic        W_READY,
  output logic [5:0]  T_IDX,
  output logic        BUSY,
  output logic        DONE
);

  sched_state_t state;
  sched_state_t state_nxt;

  logic [5:0]  cnt;
  logic [31:0] win [NLOAD];
  logic [31:0] w_new;
  logic [31:0] next_word;
  logic [31:0] out_word;

  logic adv;
  logic start_ok;
  logic load_acc;
  logic last_xfer;
  logic exp_gen;
  logic shift_en;

  // Window slots: win[0] = W_t-16 ... win[15] = W_t-1 for the next index t.
  sha256_w_sigma u_sigma (
    .w_m2  (win[14]),
    .w_m7  (win[9]),
    .w_m15 (win[1]),
    .w_m16 (win[0]),
    .w_new (w_new)
  );

  assign adv       = !W_VALID || W_READY;
  // DONE is high only in the first IDLE cycle; a START there is deliberately dropped.
  assign start_ok  = (state == IDLE) && START && !DONE;
  assign load_acc  = (state == LOAD) && M_VALID && M_READY;
  assign last_xfer = (state == EXPAND) && W_VALID && W_READY && (T_IDX == 6'(NROUNDS - 1));
  assign exp_gen   = (state == EXPAND) && adv && !last_xfer;
  assign shift_en  = load_acc || exp_gen;
  assign next_word = (state == LOAD) ? M_IN : w_new;

`ifdef SHA_PREADD_K_EN
  assign out_word  = next_word + K_TABLE[cnt];
`else
  assign out_word  = next_word;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the handshake/status outputs that follow directly from the state.
  always_comb begin
    state_nxt = state;
    M_READY   = 1'b0;
    BUSY      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        BUSY    = 1'b1;
        M_READY = adv;
        if (load_acc && (cnt == 6'(NLOAD - 1))) state_nxt = EXPAND;
      end
      EXPAND: begin
        BUSY = 1'b1;
        if (last_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index counter and sliding window; both move only when a new word enters the output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      for (int i = 0; i < NLOAD; i++) win[i] <= '0;
    end else begin
      if (start_ok) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt + 6'd1;
      end
      if (shift_en) begin
        for (int i = 0; i < NLOAD - 1; i++) win[i] <= win[i + 1];
        win[NLOAD - 1] <= next_word;
      end
    end
  end

  // Output register stage and the DONE pulse that follows the W_63 handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      W_OUT   <= '0;
      W_VALID <= 1'b0;
      T_IDX   <= '0;
      DONE    <= 1'b0;
    end else begin
      DONE <= last_xfer;
      if (shift_en) begin
        W_OUT   <= out_word;
        W_VALID <= 1'b1;
        T_IDX   <= cnt;
      end else if (last_xfer || ((state == LOAD) && adv)) begin
        // Word taken with nothing new behind it: the stage empties.
        W_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] M_IN;
  logic        M_VALID;
  logic        M_READY;
  logic [31:0] W_OUT;
  logic        W_VALID;
  logic        W_READY;
  logic [5:0]  T_IDX;
  logic        BUSY;
  logic        DONE;

  sha256_msg_sched dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .M_IN    (M_IN),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .W_OUT   (W_OUT),
    .W_VALID (W_VALID),
    .W_READY (W_READY),
    .T_IDX   (T_IDX),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] blk   [16];
  logic [31:0] ref_w [64];
  logic [31:0] obs   [64];
  logic [31:0] w63_ref;
  int          last_drops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule computed directly from the recurrence.
  task automatic build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ref_w[t] = blk[t];
      else ref_w[t] = ssig1(ref_w[t-2]) + ref_w[t-7] + ssig0(ref_w[t-15]) + ref_w[t-16];
    end
  endtask

  function automatic logic [31:0] expect_out(input int t);
`ifdef SHA_PREADD_K_EN
    return ref_w[t] + sha256_pkg::K_TABLE[t];
`else
    return ref_w[t];
`endif
  endfunction

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  // gap: 0 = M_VALID always, 1 = every other cycle, 2 = random
  // rdy_rand: randomise W_READY; stall_t/stall_len: hold W_READY low at that index
  // start_mid: pulse START during EXPAND; rst_t: assert RST when that index is on W_OUT (-1 = never)
  task automatic run_block(input int gap, input bit rdy_rand, input int stall_t, input int stall_len,
                           input bit start_mid, input int rst_t);
    int          cyc;
    int          widx;
    int          ntx;
    int          stalled;
    int          done_cnt;
    bit          finished;
    bit          prev_hold;
    logic [31:0] hold_w;
    logic [5:0]  hold_t;

    build_ref();
    for (int i = 0; i < 64; i++) obs[i] = 'x;
    cyc = 0; widx = 0; ntx = 0; stalled = 0; done_cnt = 0;
    finished = 0; prev_hold = 0; last_drops = 0;
    hold_w = '0; hold_t = '0;

    @(negedge CLK);
    START = 1'b1; M_VALID = 1'b0; W_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'd1);

    while (!finished && cyc < 3000) begin
      cyc++;
      if (prev_hold) begin
        check("hold_vld", 32'(W_VALID), 32'd1);
        check("hold_tidx", 32'(T_IDX), 32'(hold_t));
        check("hold_wout", W_OUT, hold_w);
      end
      if (ntx == 64) begin
        if (DONE) done_cnt++;
        check("done_pulse", 32'(DONE), 32'd1);
        check("done_wvalid", 32'(W_VALID), 32'd0);
        check("done_busy", 32'(BUSY), 32'd0);
        START = 1'b1;
        M_VALID = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        check("done_single", 32'(DONE), 32'd0);
        check("start_at_done_ignored", 32'(BUSY), 32'd0);
        finished = 1;
      end else if (rst_t >= 0 && W_VALID && (int'(T_IDX) == rst_t)) begin
        RST = 1'b1; M_VALID = 1'b0; W_READY = 1'b1; START = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_wvalid", 32'(W_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_tidx", 32'(T_IDX), 32'd0);
        check("rst_wout", W_OUT, 32'd0);
        check("rst_mready", 32'(M_READY), 32'd0);
        finished = 1;
      end else begin
        if (DONE) done_cnt++;
        if (!W_VALID && ntx > 0 && ntx < 16) last_drops++;
        case (gap)
          0:       M_VALID = (widx < 16);
          1:       M_VALID = (widx < 16) && (cyc % 2 == 0);
          default: M_VALID = (widx < 16) && ($urandom_range(0, 1) == 1);
        endcase
        M_IN = M_VALID ? blk[widx] : $urandom;
        W_READY = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (W_VALID && (int'(T_IDX) == stall_t) && stalled < stall_len) begin
          W_READY = 1'b0;
          stalled++;
        end
        START = start_mid && W_VALID && (T_IDX >= 6'd30) && (T_IDX < 6'd34);
        #1;
        if (M_VALID && M_READY) widx++;
        prev_hold = W_VALID && !W_READY;
        hold_w = W_OUT;
        hold_t = T_IDX;
        if (W_VALID && W_READY) begin
          if (ntx < 64) begin
            check("t_idx", 32'(T_IDX), 32'(ntx));
            check("w_out", W_OUT, expect_out(ntx));
            obs[ntx] = W_OUT;
          end
          ntx++;
        end
        @(negedge CLK);
      end
    end
    START = 1'b0;
    M_VALID = 1'b0;
    if (!finished) check("timeout", 32'd0, 32'd1);
    if (rst_t < 0) check("done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; M_VALID = 1'b0; M_IN = '0; W_READY = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_state_wvalid", 32'(W_VALID), 32'd0);
    check("rst_state_wout", W_OUT, 32'd0);
    check("rst_state_tidx", 32'(T_IDX), 32'd0);
    check("rst_state_busy", 32'(BUSY), 32'd0);
    check("rst_state_done", 32'(DONE), 32'd0);
    check("rst_state_mready", 32'(M_READY), 32'd0);

    // "abc" block, free-flowing.
    set_abc();
    run_block(0, 0, -1, 0, 0, -1);
`ifdef SHA_PREADD_K_EN
    check("abc_w0", obs[0], 32'hA3EC9318);
    check("abc_w16", obs[16], 32'h61626380 + 32'he49b69c1);
    check("abc_w17", obs[17], 32'h000F0000 + 32'hefbe4786);
`else
    check("abc_w0", obs[0], 32'h61626380);
    check("abc_w16", obs[16], 32'h61626380);
    check("abc_w17", obs[17], 32'h000F0000);
`endif
    check("abc_w15", obs[15], expect_out(15));
    w63_ref = expect_out(63);
    check("abc_w63", obs[63], w63_ref);

    // Five-cycle output stall at t=20.
    run_block(0, 0, 20, 5, 0, -1);
    check("stall_w63", obs[63], w63_ref);

    // M_VALID on alternate cycles during LOAD.
    run_block(1, 0, -1, 0, 0, -1);
    check("gap_w63", obs[63], w63_ref);
    check("gap_drop_seen", 32'(last_drops != 0), 32'd1);

    // START pulses during EXPAND must be ignored.
    run_block(0, 0, -1, 0, 1, -1);
    check("startmid_w63", obs[63], w63_ref);

    // Reset mid-block, then a clean block.
    run_block(0, 0, -1, 0, 0, 30);
    run_block(0, 0, -1, 0, 0, -1);
`ifdef SHA_PREADD_K_EN
    check("post_rst_w16", obs[16], 32'h61626380 + 32'he49b69c1);
`else
    check("post_rst_w16", obs[16], 32'h61626380);
`endif

    // Random blocks with random input gaps and output backpressure.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      run_block(2, 1, -1, 0, (b % 2) == 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
